// File: rtl/sdram_cmd_arbiter_if.sv
// SdramCtrl-style cmd/rsp stream pair. CTX_W is 7 on requester ports, 8 on the controller port.
// master drives commands and consumes responses; slave is the opposite end.
interface sdram_cmd_arbiter_if #(
    parameter int CTX_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [23:0]      cmd_payload_address;
    logic             cmd_payload_write;
    logic [15:0]      cmd_payload_data;
    logic [1:0]       cmd_payload_mask;
    logic [CTX_W-1:0] cmd_payload_context;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_payload_data;
    logic [CTX_W-1:0] rsp_payload_context;

    modport master (
        output cmd_valid, cmd_payload_address, cmd_payload_write,
               cmd_payload_data, cmd_payload_mask, cmd_payload_context,
        input  cmd_ready,
        input  rsp_valid, rsp_payload_data, rsp_payload_context,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_payload_address, cmd_payload_write,
               cmd_payload_data, cmd_payload_mask, cmd_payload_context,
        output cmd_ready,
        output rsp_valid, rsp_payload_data, rsp_payload_context,
        input  rsp_ready
    );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of one SdramCtrl cmd/rsp stream, with in-flight cap.
// Optional macro SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins contention (no round-robin state).
module sdram_cmd_arbiter #(
    parameter int MAX_PENDING = 8,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_cmd_arbiter_if.slave   s0,
    sdram_cmd_arbiter_if.slave   s1,
    sdram_cmd_arbiter_if.master  io
);
    logic             run;
    logic             blocked;
    logic             grant;
    logic             prio_port;
    logic             cmd_fire;
    logic             rsp_fire;
    logic             rsp_id;
    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready_vec;
    logic [1:0]       cmd_ready_vec;
    logic [1:0]       rsp_valid_vec;

    logic             lock_reg, lock_next;
    logic             lock_id_reg, lock_id_next;
    logic [CNT_W-1:0] pending_reg, pending_next;

    // Outputs are forced quiet while reset is held low.
    assign run       = reset;
    assign blocked   = (pending_reg == CNT_W'(MAX_PENDING));
    assign req_valid = {s1.cmd_valid, s0.cmd_valid};
    assign rsp_ready_vec = {s1.rsp_ready, s0.rsp_ready};
    assign rsp_id    = io.rsp_payload_context[7];

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign prio_port = 1'b0;
`else
    logic rr_prio_reg, rr_prio_next;

    assign prio_port    = rr_prio_reg;
    assign rr_prio_next = cmd_fire ? ~grant : rr_prio_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_prio_reg <= 1'b0;
        end else begin
            rr_prio_reg <= rr_prio_next;
        end
    end
`endif

    always_comb begin
        grant = 1'b0;
        if (lock_reg) begin
            grant = lock_id_reg;
        end else if (s0.cmd_valid && s1.cmd_valid) begin
            grant = prio_port;
        end else if (s1.cmd_valid) begin
            grant = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign cmd_ready_vec[gi] = run && !blocked && io.cmd_ready && (grant == 1'(gi));
            assign rsp_valid_vec[gi] = run && io.rsp_valid && (rsp_id == 1'(gi));
        end
    endgenerate

    assign s0.cmd_ready = cmd_ready_vec[0];
    assign s1.cmd_ready = cmd_ready_vec[1];

    assign io.cmd_valid           = run && !blocked && req_valid[grant];
    assign io.cmd_payload_address = grant ? s1.cmd_payload_address : s0.cmd_payload_address;
    assign io.cmd_payload_write   = grant ? s1.cmd_payload_write   : s0.cmd_payload_write;
    assign io.cmd_payload_data    = grant ? s1.cmd_payload_data    : s0.cmd_payload_data;
    assign io.cmd_payload_mask    = grant ? s1.cmd_payload_mask    : s0.cmd_payload_mask;
    assign io.cmd_payload_context = {grant, (grant ? s1.cmd_payload_context : s0.cmd_payload_context)};

    assign s0.rsp_valid           = rsp_valid_vec[0];
    assign s1.rsp_valid           = rsp_valid_vec[1];
    assign s0.rsp_payload_data    = io.rsp_payload_data;
    assign s1.rsp_payload_data    = io.rsp_payload_data;
    assign s0.rsp_payload_context = io.rsp_payload_context[6:0];
    assign s1.rsp_payload_context = io.rsp_payload_context[6:0];
    assign io.rsp_ready           = run && rsp_ready_vec[rsp_id];

    assign cmd_fire = io.cmd_valid && io.cmd_ready;
    assign rsp_fire = io.rsp_valid && io.rsp_ready;

    // A stalled command freezes the grant so the downstream stream stays stable.
    always_comb begin
        lock_next    = lock_reg;
        lock_id_next = lock_id_reg;
        if (cmd_fire) begin
            lock_next = 1'b0;
        end else if (io.cmd_valid) begin
            lock_next    = 1'b1;
            lock_id_next = grant;
        end
    end

    // A stray response at zero pending is still routed but cannot underflow the count.
    always_comb begin
        pending_next = pending_reg;
        if (cmd_fire && !rsp_fire) begin
            pending_next = pending_reg + CNT_W'(1);
        end else if (rsp_fire && !cmd_fire && (pending_reg != '0)) begin
            pending_next = pending_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_reg    <= 1'b0;
            lock_id_reg <= 1'b0;
            pending_reg <= '0;
        end else begin
            lock_reg    <= lock_next;
            lock_id_reg <= lock_id_next;
            pending_reg <= pending_next;
        end
    end
endmodule
